// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with a power-on clear sequencer.
// Define REGFILE_SCOREBOARD_EN to add per-entry busy bits (alloc/writeback scoreboard).
module regfile_mp #(
  parameter int DATAW    = 32,
  parameter int ADDRW    = 6,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   we,
  input  logic [ADDRW-1:0]       wa,
  input  logic [DATAW-1:0]       wd,
  input  logic                   re,
  input  logic [NREAD*ADDRW-1:0] ra,
  output logic [NREAD*DATAW-1:0] rd,
  output logic                   ready
`ifdef REGFILE_SCOREBOARD_EN
  ,
  input  logic                   alloc_en,
  input  logic [ADDRW-1:0]       alloc_addr,
  output logic [NREAD-1:0]       rbusy
`endif
);

  localparam int DEPTH = 1 << ADDRW;

  if (NREAD < 1 || NREAD > 4) begin : g_bad_nread
    $error("regfile_mp: NREAD must be in the range 1..4");
  end

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

  state_e                 state_q;
  logic [ADDRW-1:0]       cnt_q;
  logic                   ready_q;
  logic [DATAW-1:0]       mem_q [DEPTH];
  logic [NREAD*DATAW-1:0] rd_q;
  logic [NREAD*DATAW-1:0] rd_d;
  logic                   wrDrop;
  logic                   wrOk;

  assign wrDrop = (ZERO_REG != 0) && (wa == '0);
  assign wrOk   = (state_q == ST_READY) && we && !wrDrop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          cnt_q <= cnt_q + ADDRW'(1);
          if (cnt_q == '1) begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_READY;
        end
      endcase
    end
  end

  // Storage has no reset; the clear sequencer zeroes one entry per edge instead.
  always_ff @(posedge clk) begin
    if (rstn && (state_q == ST_CLEAR)) begin
      mem_q[cnt_q] <= '0;
    end else if (wrOk) begin
      mem_q[wa] <= wd;
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [NREAD-1:0] rbusy_q;
  logic [NREAD-1:0] rbusy_d;

  // Alloc is applied after the write-clear so that a same-edge alloc wins.
  always_comb begin
    busy_d = busy_q;
    if (state_q != ST_READY) begin
      busy_d = '0;
    end else begin
      if (wrOk) busy_d[wa] = 1'b0;
      if (alloc_en) busy_d[alloc_addr] = 1'b1;
      if (ZERO_REG != 0) busy_d[0] = 1'b0;
    end
  end
`endif

  for (genvar i = 0; i < NREAD; i++) begin : g_port
    logic [ADDRW-1:0] addr;
    logic [DATAW-1:0] val;

    assign addr = ra[i*ADDRW +: ADDRW];

    always_comb begin
      val = mem_q[addr];
      if (wrOk && (wa == addr)) val = wd;
      if ((ZERO_REG != 0) && (addr == '0)) val = '0;
    end

    assign rd_d[i*DATAW +: DATAW] = val;
`ifdef REGFILE_SCOREBOARD_EN
    assign rbusy_d[i] = busy_d[addr];
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      rd_q <= '0;
    end else if (re) begin
      rd_q <= rd_d;
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q  <= '0;
      rbusy_q <= '0;
    end else begin
      busy_q <= busy_d;
      if (state_q == ST_CLEAR) begin
        rbusy_q <= '0;
      end else if (re) begin
        rbusy_q <= rbusy_d;
      end
    end
  end

  assign rbusy = rbusy_q;
`endif

  assign rd    = rd_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: two instances (ZERO_REG=1 and ZERO_REG=0) share stimulus.
// Busy-bit outputs are checked when REGFILE_SCOREBOARD_EN is defined.
module tb_regfile_mp;

  localparam int DATAW = 32;
  localparam int ADDRW = 4;
  localparam int NREAD = 2;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  wa = '0;
  logic [31:0] wd = '0;
  logic        re = 1'b0;
  logic [7:0]  ra = '0;
  logic        allocEn = 1'b0;
  logic [3:0]  allocAddr = '0;

  logic [63:0] rdZ;
  logic [63:0] rdN;
  logic        readyZ;
  logic        readyN;
`ifdef REGFILE_SCOREBOARD_EN
  logic [1:0]  rbusyZ;
  logic [1:0]  rbusyN;
`endif

  always #5 clk = ~clk;

  regfile_mp #(.DATAW(DATAW), .ADDRW(ADDRW), .NREAD(NREAD), .ZERO_REG(1)) dutZ (
    .clk(clk), .rstn(rstn), .we(we), .wa(wa), .wd(wd), .re(re), .ra(ra),
    .rd(rdZ), .ready(readyZ)
`ifdef REGFILE_SCOREBOARD_EN
    , .alloc_en(allocEn), .alloc_addr(allocAddr), .rbusy(rbusyZ)
`endif
  );

  regfile_mp #(.DATAW(DATAW), .ADDRW(ADDRW), .NREAD(NREAD), .ZERO_REG(0)) dutN (
    .clk(clk), .rstn(rstn), .we(we), .wa(wa), .wd(wd), .re(re), .ra(ra),
    .rd(rdN), .ready(readyN)
`ifdef REGFILE_SCOREBOARD_EN
    , .alloc_en(allocEn), .alloc_addr(allocAddr), .rbusy(rbusyN)
`endif
  );

  typedef struct {
    logic [63:0] rdZ;
    logic [63:0] rdN;
    logic        ready;
    logic [1:0]  rbusy;
  } exp_t;

  exp_t expQ[$];

  // Reference model: plain arrays plus a count of edges since reset.
  logic [31:0] memZ [DEPTH];
  logic [31:0] memN [DEPTH];
  bit          busyM [DEPTH];
  int          edgesSinceReset = 0;
  logic [63:0] rdZm = '0;
  logic [63:0] rdNm = '0;
  logic [1:0]  rbusyM = '0;

  int nVectors = 0;
  int nMiscompares = 0;

  task automatic applyStimulus(input logic rstnV, input logic weV, input logic [3:0] waV,
                               input logic [31:0] wdV, input logic reV, input logic [3:0] ra0,
                               input logic [3:0] ra1, input logic allocV, input logic [3:0] aaV);
    exp_t e;
    logic okZ;
    logic okN;
    logic [3:0] a;
    @(negedge clk);
    rstn = rstnV; we = weV; wa = waV; wd = wdV; re = reV; ra = {ra1, ra0};
    allocEn = allocV; allocAddr = aaV;
    if (!rstn) begin
      edgesSinceReset = 0;
      rdZm = '0; rdNm = '0; rbusyM = '0;
      foreach (busyM[k]) busyM[k] = 1'b0;
    end else if (edgesSinceReset < DEPTH) begin
      memZ[edgesSinceReset] = '0;
      memN[edgesSinceReset] = '0;
      rdZm = '0; rdNm = '0; rbusyM = '0;
      foreach (busyM[k]) busyM[k] = 1'b0;
      edgesSinceReset++;
    end else begin
      okZ = we && (wa != 4'd0);
      okN = we;
      if (okZ) busyM[wa] = 1'b0;
      if (allocEn) busyM[allocAddr] = 1'b1;
      busyM[0] = 1'b0;
      if (re) begin
        for (int p = 0; p < NREAD; p++) begin
          a = (p == 0) ? ra0 : ra1;
          if (a == 4'd0) rdZm[p*32 +: 32] = '0;
          else if (okZ && wa == a) rdZm[p*32 +: 32] = wd;
          else rdZm[p*32 +: 32] = memZ[a];
          rdNm[p*32 +: 32] = (okN && wa == a) ? wd : memN[a];
          rbusyM[p] = busyM[a];
        end
      end
      if (okZ) memZ[wa] = wd;
      if (okN) memN[wa] = wd;
    end
    e.rdZ = rdZm; e.rdN = rdNm; e.ready = (edgesSinceReset >= DEPTH); e.rbusy = rbusyM;
    expQ.push_back(e);
  endtask

  task automatic compareField(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    compareField("rd_zero_reg1", rdZ, e.rdZ);
    compareField("rd_zero_reg0", rdN, e.rdN);
    compareField("ready_zero_reg1", 64'(readyZ), 64'(e.ready));
    compareField("ready_zero_reg0", 64'(readyN), 64'(e.ready));
`ifdef REGFILE_SCOREBOARD_EN
    compareField("rbusy_zero_reg1", 64'(rbusyZ), 64'(e.rbusy));
`endif
  endtask

  // Monitor: outputs update on every rising edge, so one record is retired per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    int waitCycles;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Clear phase; the write at the sixth edge must be ignored.
    for (int k = 0; k < DEPTH; k++)
      applyStimulus(1, (k == 5), 4'd2, 32'h5555_5555, 1, 4'(k), 4'(15 - k), 0, 0);
    for (int k = 0; k < 8; k++)
      applyStimulus(1, 0, 0, 0, 1, 4'(k), 4'(k + 8), 0, 0);

    applyStimulus(1, 1, 4'd3, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 4'd3, 4'd3, 0, 0);
    applyStimulus(1, 1, 4'd7, 32'h1234_5678, 1, 4'd7, 4'd0, 0, 0);
    applyStimulus(1, 1, 4'd0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 4'd0, 4'd3, 0, 0);
    for (int k = 0; k < 3; k++)
      applyStimulus(1, 1, 4'd5, 32'hA5A5_A5A5, 0, 4'd5, 4'(k), 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 4'd5, 4'd7, 0, 0);

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 4'd9);
    applyStimulus(1, 0, 0, 0, 1, 4'd9, 4'd9, 0, 0);
    applyStimulus(1, 1, 4'd9, 32'h0000_0001, 1, 4'd9, 4'd3, 1, 4'd9);
    applyStimulus(1, 1, 4'd9, 32'h0000_0002, 1, 4'd9, 4'd9, 0, 0);

    // Reset mid-operation, then again partway through the clear.
    applyStimulus(0, 0, 0, 0, 1, 4'd9, 4'd3, 0, 0);
    for (int k = 0; k < 7; k++)
      applyStimulus(1, 1, 4'(k), 32'hCAFE_0000, 1, 4'(k), 4'd9, 1, 4'(k));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int k = 0; k < 500; k++) begin
      applyStimulus(($urandom_range(0, 149) != 0), ($urandom_range(0, 1) == 1),
                    4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) != 0),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 10) begin
      @(posedge clk);
      #4;
      waitCycles++;
    end
    if (expQ.size() > 0) begin
      nMiscompares++;
      $display("[TB] FAIL drain: got %0d records pending, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
